swi_conditioner: RTL and testbench
==================================

# swi_conditioner

Input-conditioning stage between the raw board switches and the hex counter / sequence detector logic. It synchronizes each switch bit into the clk_2 domain and debounces it with a per-bit stability counter. It publishes a clean switch vector plus single-cycle rise/fall pulses, so downstream control bits (reset request, count direction, load, serial in_bit) and the Data_in nibble change only on stable, registered values.

## Interface
- NBITS, 8, number of switch bits conditioned.
- DEBOUNCE_CYCLES, 3, consecutive synchronized cycles a new level must hold before it is accepted; legal range 1..255.
- clk_2  input  1  system clock (divided reference clock).
- reset  input  1  reset, asynchronous, active-high.
- swi_raw  input  NBITS  raw, asynchronous switch levels.
- swi_clean  output  NBITS  debounced, registered switch levels.
- swi_rise  output  NBITS  one-cycle pulse per bit when swi_clean bit goes 0->1.
- swi_fall  output  NBITS  one-cycle pulse per bit when swi_clean bit goes 1->0.
- swi_changed  output  1  OR of all rise/fall bits, registered with them.

## Operation
- Per bit: two-flop synchronizer sync1 <= swi_raw, sync2 <= sync1. Downstream logic uses only sync2.
- Per-bit stability counter cnt, width $clog2(DEBOUNCE_CYCLES+1). Each clk_2 edge, in priority order:
  - sync2 == clean: cnt <= 0; no pulse.
  - sync2 != clean and cnt == DEBOUNCE_CYCLES-1: clean <= sync2; cnt <= 0; rise (or fall) <= 1 for exactly this cycle.
  - Otherwise: cnt <= cnt+1.
- Any bounce back to the clean level before acceptance clears cnt, so the stability window restarts from zero.
- rise/fall are registered and drop to 0 on the next edge unless another accepted transition occurs. They cannot be high two cycles in a row for the same bit, because the counter must refill first.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses. swi_changed = |(rise|fall), registered in the same cycle.
- Counters never wrap: cnt saturates by rule and never exceeds DEBOUNCE_CYCLES-1.
- No valid/ready handshake. Outputs are level/pulse signals that downstream samples every cycle.

## Timing
- Reset (async assert, synchronous release by clk_2) clears sync1, sync2, cnt, swi_clean, swi_rise, swi_fall and swi_changed to 0 immediately.
- Latency: a raw level captured into sync1 at edge k appears on swi_clean, and its pulse rises, at edge k+1+DEBOUNCE_CYCLES, if held stable.
- A switch held high through reset is treated as a transition. After release it produces a rise pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Reset asserted mid-count aborts the pending transition. No pulse is emitted, including one due on the same edge.
- A pulse of raw input shorter than DEBOUNCE_CYCLES clk_2 periods (as seen at sync2) is discarded.
- DEBOUNCE_CYCLES = 1 degenerates to synchronizer plus edge detector, with a latency of 2 edges.

## Structure
- Shared package (top_pkg): NBITS_TOP reuse for NBITS, and the constant DEBOUNCE_DEFAULT = 3.
- Sub-module swi_debounce_bit: one bit holding sync1/sync2/cnt/clean/rise/fall, with parameter DEBOUNCE_CYCLES. The top level instantiates it NBITS times in a generate loop and ORs the pulses into swi_changed.

## Test plan
- Reset with swi_raw = 8'h00 -> all outputs 0. Assert reset asynchronously between edges -> outputs 0 before the next edge.
- DEBOUNCE_CYCLES=3, swi_raw[3] 0->1 captured at edge 10 -> swi_clean[3]=1 and swi_rise[3]=1 at edge 14, swi_rise[3]=0 at edge 15, swi_changed mirrors it.
- Bounce: swi_raw[1] high for 2 cycles, low for 1, then high steady -> no pulse during the bounce; rise occurs 4 edges after the final capture.
- Simultaneous: swi_raw 8'h00->8'hF0 on one edge -> swi_clean=8'hF0 and swi_rise=8'hF0 on the same edge, swi_fall=0.
- Fall: from swi_clean[0]=1, drop swi_raw[0] -> swi_fall[0] pulse after 4 edges, swi_clean[0]=0.
- Reset mid-count: raise swi_raw[2], assert reset at cnt=1 and release with raw still high -> no pulse during reset; rise occurs a full latency after release.

Source files
------------

// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared constants for the switch conditioning path
package top_pkg;

    localparam int NBITS_TOP        = 8;
    localparam int DEBOUNCE_DEFAULT = 3;

    // Counter wide enough to hold 0..cycles, so cycles-1 is always reachable.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/swi_debounce_bit.sv
// rtl/swi_debounce_bit.sv - one switch bit: 2-flop synchronizer, stability counter, edge pulses
module swi_debounce_bit
    import top_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_2,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic pulse_next
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Any return to the accepted level restarts the stability window.
        if (sync2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean      = clean_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign pulse_next = rise_d | fall_d;

endmodule

// File: rtl/swi_conditioner.sv
// rtl/swi_conditioner.sv - debounced switch vector with per-bit rise/fall pulses
module swi_conditioner
    import top_pkg::*;
#(
    parameter int NBITS           = NBITS_TOP,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_clean,
    output logic [NBITS-1:0] swi_rise,
    output logic [NBITS-1:0] swi_fall,
    output logic             swi_changed
);

    // Reset asserts immediately but releases on a clk_2 edge.
    logic rst_q, rst_d;

    always_comb begin
        rst_d = 1'b0;
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= rst_d;
        end
    end

    logic [NBITS-1:0] pulse_next;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        swi_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_2      (clk_2),
            .reset      (rst_q),
            .raw        (swi_raw[i]),
            .clean      (swi_clean[i]),
            .rise       (swi_rise[i]),
            .fall       (swi_fall[i]),
            .pulse_next (pulse_next[i])
        );
    end

    // Registered from the bits' next-state pulses so it lines up with rise/fall.
    logic changed_q, changed_d;

    always_comb begin
        changed_d = |pulse_next;
    end

    always_ff @(posedge clk_2 or posedge rst_q) begin
        if (rst_q) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign swi_changed = changed_q;

endmodule

// File: tb/tb_swi_conditioner.sv
// tb/tb_swi_conditioner.sv - scoreboard bench for swi_conditioner (NBITS=8, DEBOUNCE_CYCLES=3)
module tb_swi_conditioner;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] swi_raw;
    logic [7:0] swi_clean;
    logic [7:0] swi_rise;
    logic [7:0] swi_fall;
    logic       swi_changed;

    swi_conditioner #(
        .NBITS           (8),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .swi_raw     (swi_raw),
        .swi_clean   (swi_clean),
        .swi_rise    (swi_rise),
        .swi_fall    (swi_fall),
        .swi_changed (swi_changed)
    );

    always #5 clk_2 = ~clk_2;

    int cyc = 0;
    always @(posedge clk_2) cyc <= cyc + 1;

    typedef struct {
        int         at_edge;
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Capture at edge c+1, then 1+DEBOUNCE_CYCLES more edges.
    task automatic expect_pulse(input int at_edge, input logic [7:0] c,
                                input logic [7:0] r, input logic [7:0] f);
        exp_t e;
        e.at_edge = at_edge;
        e.clean   = c;
        e.rise    = r;
        e.fall    = f;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_2) begin
        exp_t e;
        if (swi_changed || (swi_rise != 8'h00) || (swi_fall != 8'h00)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {swi_rise, swi_fall}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_edge", cyc, e.at_edge);
                check("pulse_clean", swi_clean, e.clean);
                check("pulse_rise", swi_rise, e.rise);
                check("pulse_fall", swi_fall, e.fall);
                check("pulse_changed", swi_changed, 1);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].at_edge) begin
            e = exp_q.pop_front();
            check("missed_pulse_edge", cyc, e.at_edge);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    initial begin
        reset   = 1'b1;
        swi_raw = 8'h00;
        wait_neg(3);
        check("reset_clean", swi_clean, 8'h00);
        check("reset_rise", swi_rise, 8'h00);
        check("reset_fall", swi_fall, 8'h00);
        check("reset_changed", swi_changed, 0);
        reset = 1'b0;

        // Single rise on bit 3
        wait_neg(5);
        swi_raw = 8'h08;
        expect_pulse(cyc + 5, 8'h08, 8'h08, 8'h00);
        wait_neg(8);
        check("clean_after_rise", swi_clean, 8'h08);

        // Bounce on bit 1: high 2, low 1, then steady high
        swi_raw = 8'h0A;
        wait_neg(2);
        swi_raw = 8'h08;
        wait_neg(1);
        swi_raw = 8'h0A;
        expect_pulse(cyc + 5, 8'h0A, 8'h02, 8'h00);
        wait_neg(8);
        check("clean_after_bounce", swi_clean, 8'h0A);

        // Two simultaneous falls
        swi_raw = 8'h00;
        expect_pulse(cyc + 5, 8'h00, 8'h00, 8'h0A);
        wait_neg(8);
        check("clean_after_fall2", swi_clean, 8'h00);

        // Four simultaneous rises
        swi_raw = 8'hF0;
        expect_pulse(cyc + 5, 8'hF0, 8'hF0, 8'h00);
        wait_neg(8);
        check("clean_after_f0", swi_clean, 8'hF0);

        // Bit 0 up then down
        swi_raw = 8'hF1;
        expect_pulse(cyc + 5, 8'hF1, 8'h01, 8'h00);
        wait_neg(8);
        swi_raw = 8'hF0;
        expect_pulse(cyc + 5, 8'hF0, 8'h00, 8'h01);
        wait_neg(8);
        check("clean_after_fall0", swi_clean, 8'hF0);

        // Reset asserted between edges with bit 2 at cnt=1
        swi_raw = 8'hF4;
        wait_neg(3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_clean", swi_clean, 8'h00);
        check("async_reset_rise", swi_rise, 8'h00);
        check("async_reset_fall", swi_fall, 8'h00);
        check("async_reset_changed", swi_changed, 0);
        wait_neg(2);
        check("held_reset_clean", swi_clean, 8'h00);
        reset = 1'b0;
        // First post-reset edge releases; capture one edge later.
        expect_pulse(cyc + 6, 8'hF4, 8'hF4, 8'h00);
        wait_neg(10);
        check("clean_after_reset", swi_clean, 8'hF4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
